// File: rtl/cs_mac_pkg.sv
// Shared types and widths for the carry-save MAC stage.
// Imported by the interface, multiplier and accumulator.
package cs_mac_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } mac_state_t;

endpackage

// File: rtl/cs_mac_if.sv
// Operand-in / result-out handshake bundle for cs_mac_accumulator.
// master drives operands and out_ready; slave is the accumulator.
interface cs_mac_if #(
  parameter int ACC_W = 12
);
  import cs_mac_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_count, out_ovf
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, out_sum,
    output out_count, out_ovf
  );

endinterface

// File: rtl/cs_mac_accumulator_multiCS4_v1.sv
// 4x4 unsigned carry-save array multiplier, purely combinational.
// Rows reduce in carry-save form; one final carry-propagate add.
module multiCS4_v1
  import cs_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] s;
  logic [PROD_W-1:0] c;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] t;

  always_comb begin
    s  = '0;
    c  = '0;
    pp = '0;
    t  = '0;
    for (int i = 0; i < OP_W; i++) begin
      pp = {{(PROD_W-OP_W){1'b0}},
            a & {OP_W{b[i]}}} << i;
      t  = s ^ c ^ pp;
      c  = ((s & c) | (s & pp) | (c & pp)) << 1;
      s  = t;
    end
  end

  // 225 max fits in PROD_W, so dropped top carries are always zero
  assign p = s + c;

endmodule

// File: rtl/cs_mac_accumulator.sv
// Product register plus group accumulator with a held result port.
// A product pending during HOLD waits in P until the result is taken.
module cs_mac_accumulator
  import cs_mac_pkg::*;
#(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  cs_mac_if.slave bus
);

  mac_state_t state_q;
  mac_state_t state_d;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] p_q;
  logic              p_valid;
  logic              p_last;

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;

  logic              acc_take;
  logic              accept;
  logic              done;
  logic              hs_out;
  logic [ACC_W-1:0]  base;
  logic [ACC_W:0]    sum_full;
  logic [CNT_W:0]    cnt_nx;

  multiCS4_v1 u_mult (
    .a (bus.a),
    .b (bus.b),
    .p (prod)
  );

  assign acc_take = p_valid && (state_q == ACC);
  assign accept   = bus.in_valid && bus.in_ready;
  assign hs_out   = (state_q == HOLD) && bus.out_ready;

  assign base     = (cnt == '0) ? '0 : acc;
  assign sum_full = {1'b0, base}
                  + {{(ACC_W+1-PROD_W){1'b0}}, p_q};
  assign cnt_nx   = {1'b0, cnt} + (CNT_W+1)'(1);
  assign done     = p_last
                 || (cnt_nx == (CNT_W+1)'(MAX_TERMS));

  assign bus.in_ready  = !p_valid || acc_take;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc;
  assign bus.out_count = cnt;
  assign bus.out_ovf   = ovf;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:  if (acc_take && done) state_d = HOLD;
      HOLD: if (bus.out_ready)    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (accept) begin
      p_q     <= prod;
      p_valid <= 1'b1;
      p_last  <= bus.in_last;
    end else if (acc_take) begin
      p_valid <= 1'b0;
    end
  end

  // first term of a group ignores any stale history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (acc_take) begin
      acc <= sum_full[ACC_W-1:0];
      ovf <= ((cnt == '0) ? 1'b0 : ovf)
           | sum_full[ACC_W];
      cnt <= cnt_nx[CNT_W-1:0];
    end else if (hs_out) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cs_mac_accumulator.sv
// Scoreboard bench for cs_mac_accumulator, 12-bit and 8-bit builds.
// Stimulus pushes expected results; negedge monitors pop and compare.
module tb_cs_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cs_mac_if #(.ACC_W(12)) bus ();
  cs_mac_if #(.ACC_W(8))  bus8 ();

  cs_mac_accumulator #(
    .ACC_W(12), .MAX_TERMS(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cs_mac_accumulator #(
    .ACC_W(8), .MAX_TERMS(16)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic exp_t mk(int s, int c, int o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none",
                 bus.out_sum);
      end else begin
        e = q.pop_front();
        check("sum", int'(bus.out_sum), e.sum);
        check("count", int'(bus.out_count), e.cnt);
        check("ovf", int'(bus.out_ovf), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result8: got %0d expected none",
                 bus8.out_sum);
      end else begin
        e = q8.pop_front();
        check("sum8", int'(bus8.out_sum), e.sum);
        check("count8", int'(bus8.out_count), e.cnt);
        check("ovf8", int'(bus8.out_ovf), e.ovf);
      end
    end
  end

  task automatic send(input int av, input int bv,
                      input int last);
    int n;
    bus.in_valid = 1'b1;
    bus.a        = 4'(av);
    bus.b        = 4'(bv);
    bus.in_last  = (last != 0);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send8(input int av, input int bv,
                       input int last);
    int n;
    bus8.in_valid = 1'b1;
    bus8.a        = 4'(av);
    bus8.b        = 4'(bv);
    bus8.in_last  = (last != 0);
    n = 0;
    @(negedge clk);
    while (!bus8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send8_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || q8.size() != 0
            || bus.out_valid || bus8.out_valid)
           && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("idle_timeout", 1, 0);
    if (n >= 100) begin
      q.delete();
      q8.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.in_last   = 1'b0;
    bus8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_sum", int'(bus.out_sum), 0);
    check("rst_out_count", int'(bus.out_count), 0);
    check("rst_out_ovf", int'(bus.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 12 + 70 + 126 + 36
    q.push_back(mk(244, 4, 0));
    send(3, 4, 0);
    send(10, 7, 0);
    send(9, 14, 0);
    send(6, 6, 1);
    check("lat_k", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_k1", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    check("lat_k2", int'(bus.out_valid), 0);
    wait_idle();

    q.push_back(mk(0, 1, 0));
    send(0, 12, 1);
    wait_idle();

    // 16 * 225 forced close, 17th pair opens a new group
    q.push_back(mk(3600, 16, 0));
    q.push_back(mk(65, 1, 0));
    for (int i = 0; i < 16; i++) send(15, 15, 0);
    send(5, 13, 1);
    wait_idle();

    bus.out_ready = 1'b0;
    q.push_back(mk(121, 1, 0));
    q.push_back(mk(13, 2, 0));
    send(11, 11, 1);
    fork
      begin
        send(2, 2, 0);
        send(3, 3, 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_sum", int'(bus.out_sum), 121);
        check("hold_count", int'(bus.out_count), 1);
        check("hold_in_ready", int'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
      end
    join
    wait_idle();

    // 225 + 225 = 450 wraps to 194 in 8 bits
    q8.push_back(mk(194, 2, 1));
    q8.push_back(mk(65, 1, 0));
    send8(15, 15, 0);
    send8(15, 15, 1);
    send8(5, 13, 1);
    wait_idle();

    send(3, 4, 0);
    send(10, 7, 0);
    @(posedge clk);
    #1;
    check("pre_rst_count", int'(bus.out_count), 2);
    check("pre_rst_sum", int'(bus.out_sum), 82);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", int'(bus.out_sum), 0);
    check("mid_rst_count", int'(bus.out_count), 0);
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(65, 1, 0));
    send(5, 13, 1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_mac_accumulator.md
# cs_mac_accumulator

Sequential multiply-accumulate stage sitting directly downstream of the team's 4x4 carry-save multiplier (multiCS4_v1). It accepts a stream of 4-bit operand pairs over a valid/ready handshake, registers each 8-bit product, and sums a group of products, the group being terminated by `in_last` or by a term limit. The finished dot-product sum is presented on a valid/ready output port and held until it is consumed.

## Interface
- `ACC_W`, default 12: accumulator and result width. Legal range is 8..16.
- `MAX_TERMS`, default 16: maximum number of products per group. Reaching it forces group termination. Legal range is 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept an operand pair.
- `a`  in  4  multiplicand, unsigned.
- `b`  in  4  multiplier, unsigned.
- `in_last`  in  1  this pair is the final term of its group.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  group sum, modulo 2^ACC_W.
- `out_count`  out  8  number of terms in the group.
- `out_ovf`  out  1  sticky: the group sum exceeded 2^ACC_W-1.

## Operation
- Product stage (P):
  - Registers `p_q[7:0]` = a*b, taken from an internal multiCS4_v1 instance, together with `p_valid` and `p_last`.
  - An operand pair is accepted when `in_valid && in_ready`.
  - `in_ready = !p_valid || acc_take`.
  - `acc_take = p_valid && state==ACC`.
- Accumulate FSM, states ACC and HOLD. Reset state is ACC.
  - ACC, on `acc_take`:
    - `acc <= (cnt==0 ? 0 : acc) + p_q`, truncated to ACC_W.
    - `ovf` is set if the full-width sum carries out of ACC_W.
    - `cnt <= cnt+1`.
    - If `p_last` or `cnt+1==MAX_TERMS`, go to HOLD.
  - HOLD:
    - `out_valid=1`; `out_sum`, `out_count` and `out_ovf` are stable.
    - P stage does not drain: `in_ready = !p_valid`.
    - On `out_ready`: go to ACC, clear `cnt`, `acc` and `ovf`.
- A product waiting in P while in HOLD is consumed on the first ACC cycle after the handshake. There is no bypass from HOLD into accumulation.
- `in_last` with no accumulated history (first term) closes a 1-term group.
- Overflow wraps the sum; `ovf` stays set until the result is consumed.
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0, `p_valid`=0, state ACC.

## Timing
- Operand accepted at edge k: product is registered at k, accumulated at k+1.
- If that term is the last, `out_valid` rises after edge k+1, giving a 2-cycle latency to the result.
- Throughput is one term per cycle while in ACC.
- The output handshake completes on an edge with `out_valid && out_ready`. With a product pending in P, the next group's first accumulation occurs at the following edge.
- Backpressure: in HOLD with `out_ready` held low, P holds at most one product and `in_ready` drops the cycle after that product is captured.
- Reset asserted mid-group: all state clears immediately (asynchronously); partial sum and pending product are discarded. Deassertion is synchronous to `clk`.
- `in_valid`, `a`, `b` and `in_last` are sampled only on accepted edges. Outputs are registered.

## Structure
- Shared package `cs_mac_pkg` holds:
  - `OP_W`=4 and `PROD_W`=8.
  - The state enum `mac_state_t` {ACC, HOLD}.
  - `CNT_W`=8.
- The one natural sub-module is the existing `multiCS4_v1`, instantiated combinationally ahead of the P register. All other logic is flat in `cs_mac_accumulator`.

## Test plan
- Pairs (3,4), (10,7), (9,14), (6,6) with `in_last` on the 4th, `out_ready`=1:
  - `out_sum`=244, `out_count`=4, `out_ovf`=0.
  - `out_valid` is high for exactly one cycle, 2 cycles after the last accept.
- Single pair (0,12) with `in_last`: `out_sum`=0, `out_count`=1.
- 16 pairs of (15,15), `in_last` never asserted, defaults:
  - Forced termination: `out_sum`=3600, `out_count`=16.
  - The 17th pair starts a new group.
- `ACC_W`=8, pairs (15,15), (15,15) with `in_last`: `out_sum`=194, `out_ovf`=1. The next group (5,13) last gives 65 with `out_ovf`=0.
- Group (11,11) last, then `out_ready`=0 for 5 cycles while streaming (2,2), (3,3):
  - `out_sum` is held at 121.
  - `in_ready` falls after one buffered product.
  - After release the next group sums to 13, with no term lost or duplicated.
- Assert `rst_n`=0 after 2 of 4 terms: outputs return to their reset values immediately. A fresh group (5,13) last yields 65, `out_count`=1.
